// File: rtl/result_bcd_converter_if.sv
// result_bcd_converter_if
//   Bundles the request/result signals between the calculator datapath and the
//   BCD conversion stage.
//   master modport: drives start/select/a/b, observes busy/done and the BCD results.
//   slave modport : the converter itself.
//   Signals:
//     start      request a conversion (or a clear when select=10011)
//     select     ALU op code, 5 bits
//     a, b       primary (integer) and secondary (fraction) result words
//     busy       conversion in progress
//     done       one-cycle strobe when the BCD outputs have just been updated
//     int_bcd    packed BCD of a, most significant digit in the MSBs
//     frac_bcd   packed BCD of b (zero unless frac_valid)
//     frac_valid b was converted for this result
//     neg        a was shown as a negative magnitude
interface result_bcd_converter_if #(
  parameter int DATA_W = 16,
  parameter int DIGITS = 5
);
  logic                  start;
  logic [4:0]            select;
  logic [DATA_W-1:0]     a;
  logic [DATA_W-1:0]     b;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   int_bcd;
  logic [4*DIGITS-1:0]   frac_bcd;
  logic                  frac_valid;
  logic                  neg;

  modport master (
    output start, select, a, b,
    input  busy, done, int_bcd, frac_bcd, frac_valid, neg
  );

  modport slave (
    input  start, select, a, b,
    output busy, done, int_bcd, frac_bcd, frac_valid, neg
  );
endinterface

// File: rtl/result_bcd_converter.sv
// result_bcd_converter
//   Captures the ALU result pair and op select, then converts a (and, for divide
//   and log, also b) to packed BCD using one double-dabble iteration per clock.
//   The results appear together with a one-cycle done strobe and are held until
//   the next conversion or clear.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous, active-high reset
//   bus  result_bcd_converter_if.slave (start/select/a/b in; busy/done/BCD out)
// Configuration macro:
//   SIGNED_RESULT_EN  when defined, a subtract result with its MSB set is shown
//                     as its two's-complement magnitude with neg=1.
module result_bcd_converter #(
  parameter int DATA_W = 16,
  parameter int DIGITS = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  result_bcd_converter_if.slave     bus
);

  localparam int                 BCD_W = 4 * DIGITS;
  localparam int                 CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0]   LAST  = CNT_W'(DATA_W - 1);

  localparam logic [4:0] SEL_DIV = 5'b00011;
  localparam logic [4:0] SEL_LOG = 5'b10010;
  localparam logic [4:0] SEL_CLR = 5'b10011;
`ifdef SIGNED_RESULT_EN
  localparam logic [4:0] SEL_SUB = 5'b00001;
`endif

  typedef enum logic [1:0] {IDLE, CONV_A, CONV_B, DONE} state_t;

  state_t             state_q, state_d;
  logic [DATA_W-1:0]  shift_q, shift_d;
  logic [DATA_W-1:0]  b_hold_q, b_hold_d;
  logic               two_word_q, two_word_d;
  logic               neg_pend_q, neg_pend_d;
  logic [BCD_W-1:0]   acc_q, acc_d;
  logic [BCD_W-1:0]   int_hold_q, int_hold_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [BCD_W-1:0]   int_bcd_q, int_bcd_d;
  logic [BCD_W-1:0]   frac_bcd_q, frac_bcd_d;
  logic               frac_valid_q, frac_valid_d;
  logic               neg_q, neg_d;

  logic [BCD_W-1:0]   adj;
  logic [BCD_W-1:0]   step;

  // Add 3 to every digit that is 5 or more so the following shift carries
  // correctly into the next decimal digit.
  function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] v);
    logic [BCD_W-1:0] r;
    r = v;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] >= 4'd5) r[4*i +: 4] = v[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    b_hold_d     = b_hold_q;
    two_word_d   = two_word_q;
    neg_pend_d   = neg_pend_q;
    acc_d        = acc_q;
    int_hold_d   = int_hold_q;
    cnt_d        = cnt_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    int_bcd_d    = int_bcd_q;
    frac_bcd_d   = frac_bcd_q;
    frac_valid_d = frac_valid_q;
    neg_d        = neg_q;

    adj  = add3(acc_q);
    step = {adj[BCD_W-2:0], shift_q[DATA_W-1]};

    case (state_q)
      IDLE: begin
        // A start coinciding with the done strobe belongs to the previous
        // result's handshake and is dropped.
        if (bus.start && !done_q) begin
          if (bus.select == SEL_CLR) begin
            int_bcd_d    = '0;
            frac_bcd_d   = '0;
            frac_valid_d = 1'b0;
            neg_d        = 1'b0;
          end else begin
            shift_d    = bus.a;
            b_hold_d   = bus.b;
            two_word_d = (bus.select == SEL_DIV) || (bus.select == SEL_LOG);
            neg_pend_d = 1'b0;
`ifdef SIGNED_RESULT_EN
            if ((bus.select == SEL_SUB) && bus.a[DATA_W-1]) begin
              shift_d    = -bus.a;
              neg_pend_d = 1'b1;
            end
`endif
            acc_d   = '0;
            cnt_d   = '0;
            busy_d  = 1'b1;
            state_d = CONV_A;
          end
        end
      end

      // On the last a-iteration the finished digits are parked so the same
      // accumulator can be reused for b.
      CONV_A: begin
        acc_d   = step;
        shift_d = shift_q << 1;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == LAST) begin
          int_hold_d = step;
          acc_d      = '0;
          cnt_d      = '0;
          shift_d    = b_hold_q;
          state_d    = two_word_q ? CONV_B : DONE;
        end
      end

      CONV_B: begin
        acc_d   = step;
        shift_d = shift_q << 1;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          state_d = DONE;
        end
      end

      DONE: begin
        int_bcd_d    = int_hold_q;
        frac_bcd_d   = two_word_q ? acc_q : '0;
        frac_valid_d = two_word_q;
        neg_d        = neg_pend_q;
        done_d       = 1'b1;
        busy_d       = 1'b0;
        state_d      = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      shift_q      <= '0;
      b_hold_q     <= '0;
      two_word_q   <= 1'b0;
      neg_pend_q   <= 1'b0;
      acc_q        <= '0;
      int_hold_q   <= '0;
      cnt_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      int_bcd_q    <= '0;
      frac_bcd_q   <= '0;
      frac_valid_q <= 1'b0;
      neg_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      b_hold_q     <= b_hold_d;
      two_word_q   <= two_word_d;
      neg_pend_q   <= neg_pend_d;
      acc_q        <= acc_d;
      int_hold_q   <= int_hold_d;
      cnt_q        <= cnt_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      int_bcd_q    <= int_bcd_d;
      frac_bcd_q   <= frac_bcd_d;
      frac_valid_q <= frac_valid_d;
      neg_q        <= neg_d;
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.int_bcd    = int_bcd_q;
  assign bus.frac_bcd   = frac_bcd_q;
  assign bus.frac_valid = frac_valid_q;
  assign bus.neg        = neg_q;

endmodule

// File: tb/tb_result_bcd_converter.sv
// tb_result_bcd_converter
//   Directed stimulus for result_bcd_converter. A decimal-arithmetic model
//   predicts busy/done timing and the displayed digits; a compare process checks
//   the DUT against it every cycle, and directed checks pin literal results.
module tb_result_bcd_converter;

  localparam int DW = 16;
  localparam int DG = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int tests = 0;
  int fails = 0;

  result_bcd_converter_if #(.DATA_W(DW), .DIGITS(DG)) bus ();

  result_bcd_converter #(.DATA_W(DW), .DIGITS(DG)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Decimal digits by repeated division, least significant digit lowest.
  function automatic logic [4*DG-1:0] to_bcd(input int v);
    logic [4*DG-1:0] r;
    int x;
    r = '0;
    x = v;
    for (int i = 0; i < DG; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Model state: visible outputs plus the pending result of an accepted request.
  int              cyc = 0;
  bit              m_active = 0;
  int              m_end = 0;
  logic [4*DG-1:0] m_int = '0, m_frac = '0;
  logic            m_fv = 0, m_neg = 0;
  logic [4*DG-1:0] p_int = '0, p_frac = '0;
  logic            p_fv = 0, p_neg = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_active = 0;
      m_int = '0; m_frac = '0; m_fv = 0; m_neg = 0;
    end else begin
      int va;
      bit two;
      cyc = cyc + 1;
      if (m_active && cyc == m_end) begin
        m_int = p_int; m_frac = p_frac; m_fv = p_fv; m_neg = p_neg;
      end
      if (bus.start && (!m_active || cyc > m_end + 1)) begin
        if (bus.select == 5'b10011) begin
          m_int = '0; m_frac = '0; m_fv = 0; m_neg = 0;
          m_active = 0;
        end else begin
          va = int'(bus.a);
          p_neg = 0;
`ifdef SIGNED_RESULT_EN
          if (bus.select == 5'b00001 && va >= (1 << (DW - 1))) begin
            va = (1 << DW) - va;
            p_neg = 1;
          end
`endif
          two = (bus.select == 5'b00011) || (bus.select == 5'b10010);
          p_int  = to_bcd(va);
          p_frac = two ? to_bcd(int'(bus.b)) : '0;
          p_fv   = two;
          m_active = 1;
          m_end = cyc + (two ? 2 * DW + 1 : DW + 1);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [4:0] sel, input logic [DW-1:0] av, input logic [DW-1:0] bv);
    @(negedge clk);
    bus.start = 1'b1; bus.select = sel; bus.a = av; bus.b = bv;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic waitDone(input string name, output int n);
    n = -1;
    for (int i = 1; i <= 80; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        n = i;
        break;
      end
    end
    if (n < 0) begin
      tests++;
      fails++;
      $display("[TB] FAIL %s timeout: got no done expected done within 80 cycles", name);
    end
  endtask

  task automatic checkOutput(input string name, input logic [4*DG-1:0] e_int,
                             input logic [4*DG-1:0] e_frac, input logic e_fv, input logic e_neg);
    check({name, " int_bcd"}, 32'(bus.int_bcd), 32'(e_int));
    check({name, " frac_bcd"}, 32'(bus.frac_bcd), 32'(e_frac));
    check({name, " frac_valid"}, 32'(bus.frac_valid), 32'(e_fv));
    check({name, " neg"}, 32'(bus.neg), 32'(e_neg));
  endtask

  initial begin
    int n;
    bus.start = 1'b0; bus.select = '0; bus.a = '0; bus.b = '0;

    fork
      forever begin
        @(negedge clk);
        if (!rst) begin
          check($sformatf("cyc%0d busy", cyc), 32'(bus.busy), 32'(m_active && cyc < m_end));
          check($sformatf("cyc%0d done", cyc), 32'(bus.done), 32'(m_active && cyc == m_end));
          check($sformatf("cyc%0d int_bcd", cyc), 32'(bus.int_bcd), 32'(m_int));
          check($sformatf("cyc%0d frac_bcd", cyc), 32'(bus.frac_bcd), 32'(m_frac));
          check($sformatf("cyc%0d frac_valid", cyc), 32'(bus.frac_valid), 32'(m_fv));
          check($sformatf("cyc%0d neg", cyc), 32'(bus.neg), 32'(m_neg));
        end
      end
    join_none

    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    check("reset busy", 32'(bus.busy), 32'd0);
    check("reset done", 32'(bus.done), 32'd0);
    checkOutput("reset", 20'h0, 20'h0, 1'b0, 1'b0);

    applyStimulus(5'b00000, 16'd12345, 16'd77);
    waitDone("single", n);
    check("single latency", 32'(n), 32'd17);
    checkOutput("single", 20'h12345, 20'h0, 1'b0, 1'b0);

    // Start on the same edge done is high must be ignored.
    bus.start = 1'b1; bus.select = 5'b00000; bus.a = 16'd9;
    @(negedge clk);
    bus.start = 1'b0;
    check("start at done ignored", 32'(bus.busy), 32'd0);

    applyStimulus(5'b00010, 16'hFFFF, 16'd0);
    waitDone("max", n);
    checkOutput("max", 20'h65535, 20'h0, 1'b0, 1'b0);

    applyStimulus(5'b00010, 16'd0, 16'd0);
    waitDone("zero", n);
    checkOutput("zero", 20'h00000, 20'h0, 1'b0, 1'b0);

    applyStimulus(5'b00011, 16'd7, 16'd5000);
    waitDone("div", n);
    check("div latency", 32'(n), 32'd33);
    checkOutput("div", 20'h00007, 20'h05000, 1'b1, 1'b0);

    applyStimulus(5'b10010, 16'd1, 16'd99);
    waitDone("log", n);
    checkOutput("log", 20'h00001, 20'h00099, 1'b1, 1'b0);

    applyStimulus(5'b10100, 16'd321, 16'd55);
    waitDone("unused sel", n);
    checkOutput("unused sel", 20'h00321, 20'h0, 1'b0, 1'b0);

    // Second start while busy, and inputs changing after capture.
    applyStimulus(5'b00000, 16'd100, 16'd0);
    repeat (4) @(negedge clk);
    bus.start = 1'b1; bus.a = 16'd999; bus.b = 16'd3;
    @(negedge clk);
    bus.start = 1'b0; bus.a = 16'd1234; bus.select = 5'b00011;
    waitDone("busy start", n);
    checkOutput("busy start", 20'h00100, 20'h0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    check("busy start single done", 32'(bus.done), 32'd0);

    // Asynchronous reset mid-conversion.
    applyStimulus(5'b00000, 16'd500, 16'd0);
    repeat (7) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async rst busy", 32'(bus.busy), 32'd0);
    check("async rst done", 32'(bus.done), 32'd0);
    checkOutput("async rst", 20'h0, 20'h0, 1'b0, 1'b0);
    @(negedge clk);
    #1 rst = 1'b0;

    applyStimulus(5'b00011, 16'd42, 16'd8);
    waitDone("after rst", n);
    checkOutput("after rst", 20'h00042, 20'h00008, 1'b1, 1'b0);

    applyStimulus(5'b10011, 16'd5, 16'd5);
    check("clear busy", 32'(bus.busy), 32'd0);
    checkOutput("clear", 20'h0, 20'h0, 1'b0, 1'b0);
    repeat (20) @(negedge clk);
    check("clear no done", 32'(bus.done), 32'd0);

    applyStimulus(5'b00001, 16'hFFFE, 16'd0);
    waitDone("sub neg", n);
`ifdef SIGNED_RESULT_EN
    checkOutput("sub neg", 20'h00002, 20'h0, 1'b0, 1'b1);
`else
    checkOutput("sub neg", 20'h65534, 20'h0, 1'b0, 1'b0);
`endif

    applyStimulus(5'b00001, 16'd10, 16'd0);
    waitDone("sub pos", n);
    checkOutput("sub pos", 20'h00010, 20'h0, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
